bouncing_box_renderer: RTL and testbench

//  Pixel colour source that sits directly upstream of vga_controller and drives its color_r1/g1/b1 inputs.

---
 rtl/bouncing_box_renderer.sv | 113 +++++++++++
 tb/tb_bouncing_box_renderer.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/bouncing_box_renderer.sv
// bouncing_box_renderer: pixel source drawing a square that bounces once per frame.
// Optional white 2-pixel box border when BOX_BORDER_EN is defined.
module bouncing_box_renderer #(
    parameter int          H_ACTIVE = 640,
    parameter int          V_ACTIVE = 480,
    parameter int          BOX_SIZE = 64,
    parameter int          STEP     = 2,
    parameter logic [23:0] BOX_RGB  = 24'hFF4000,
    parameter logic [23:0] BG_RGB   = 24'h000040
) (
    input  logic       iVGA_CLK,
    input  logic       iRST,
    input  logic       iBLANK_n,
    input  logic       iHS,
    input  logic       iVS,
    input  logic       iFREEZE,
    output logic [7:0] oR,
    output logic [7:0] oG,
    output logic [7:0] oB,
    output logic       oFRAME
);
    localparam logic [0:0] SYNC_WAIT = 1'b0;
    localparam logic [0:0] ACTIVE    = 1'b1;

    logic [0:0]  r_state;
    logic        r_blank_d, r_vs_d, r_dx_neg, r_dy_neg, r_frame;
    logic [9:0]  r_x, r_y, r_bx, r_by;
    logic [23:0] r_rgb;

    logic        w_blank_fall, w_vs_fall, w_x_hi, w_x_lo, w_y_hi, w_y_lo, w_in_box;
    logic [10:0] w_bx_ext, w_by_ext, w_x_ext, w_y_ext;
    logic [9:0]  w_bx_nxt, w_by_nxt;
    logic [23:0] w_box_rgb, w_pix;

    assign w_blank_fall = r_blank_d & ~iBLANK_n;
    assign w_vs_fall    = r_vs_d & ~iVS;
    assign w_bx_ext     = {1'b0, r_bx};
    assign w_by_ext     = {1'b0, r_by};
    assign w_x_ext      = {1'b0, r_x};
    assign w_y_ext      = {1'b0, r_y};

    assign w_x_hi   = !r_dx_neg && (w_bx_ext + 11'(STEP) + 11'(BOX_SIZE) > 11'(H_ACTIVE));
    assign w_x_lo   = r_dx_neg && (w_bx_ext < 11'(STEP));
    assign w_y_hi   = !r_dy_neg && (w_by_ext + 11'(STEP) + 11'(BOX_SIZE) > 11'(V_ACTIVE));
    assign w_y_lo   = r_dy_neg && (w_by_ext < 11'(STEP));
    assign w_bx_nxt = w_x_hi ? 10'(H_ACTIVE - BOX_SIZE) : w_x_lo ? 10'd0 :
                      r_dx_neg ? r_bx - 10'(STEP) : r_bx + 10'(STEP);
    assign w_by_nxt = w_y_hi ? 10'(V_ACTIVE - BOX_SIZE) : w_y_lo ? 10'd0 :
                      r_dy_neg ? r_by - 10'(STEP) : r_by + 10'(STEP);

    assign w_in_box = (w_x_ext >= w_bx_ext) && (w_x_ext < w_bx_ext + 11'(BOX_SIZE)) &&
                      (w_y_ext >= w_by_ext) && (w_y_ext < w_by_ext + 11'(BOX_SIZE));

`ifdef BOX_BORDER_EN
    logic [9:0] w_ox, w_oy;
    assign w_ox      = r_x - r_bx;
    assign w_oy      = r_y - r_by;
    assign w_box_rgb = (w_ox < 10'd2 || w_ox >= 10'(BOX_SIZE - 2) ||
                        w_oy < 10'd2 || w_oy >= 10'(BOX_SIZE - 2)) ? 24'hFFFFFF : BOX_RGB;
`else
    assign w_box_rgb = BOX_RGB;
`endif

    assign w_pix = (iBLANK_n && r_state == ACTIVE) ? (w_in_box ? w_box_rgb : BG_RGB) : 24'd0;

    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            r_state   <= SYNC_WAIT;
            r_blank_d <= 1'b0;
            r_vs_d    <= 1'b0;
            r_x       <= 10'd0;
            r_y       <= 10'd0;
            r_bx      <= 10'((H_ACTIVE - BOX_SIZE) / 2);
            r_by      <= 10'((V_ACTIVE - BOX_SIZE) / 2);
            r_dx_neg  <= 1'b0;
            r_dy_neg  <= 1'b0;
            r_rgb     <= 24'd0;
            r_frame   <= 1'b0;
        end else begin
            r_blank_d <= iBLANK_n;
            r_vs_d    <= iVS;
            r_rgb     <= w_pix;
            r_frame   <= 1'b0;
            if (r_state == SYNC_WAIT) begin
                r_x <= 10'd0;
                r_y <= 10'd0;
                if (w_vs_fall)
                    r_state <= ACTIVE;
            end else if (w_vs_fall) begin
                r_x     <= 10'd0;
                r_y     <= 10'd0;
                r_frame <= 1'b1;
                if (!iFREEZE) begin
                    r_bx     <= w_bx_nxt;
                    r_by     <= w_by_nxt;
                    r_dx_neg <= w_x_hi | (r_dx_neg & ~w_x_lo);
                    r_dy_neg <= w_y_hi | (r_dy_neg & ~w_y_lo);
                end
            end else if (w_blank_fall) begin
                r_x <= 10'd0;
                r_y <= (r_y == 10'h3FF) ? r_y : r_y + 10'd1;
            end else if (iBLANK_n) begin
                r_x <= (r_x == 10'h3FF) ? r_x : r_x + 10'd1;
            end
        end
    end

    // HS may only go active while the line is blanked
    a_hs_align: assert property (@(posedge iVGA_CLK) disable iff (iRST) !iHS |-> !iBLANK_n);

    assign {oR, oG, oB} = r_rgb;
    assign oFRAME       = r_frame;
endmodule

// File: tb/tb_bouncing_box_renderer.sv
// tb_bouncing_box_renderer: scoreboard bench for bouncing_box_renderer (default and STEP=100 instances).
module tb_bouncing_box_renderer;
    localparam logic [23:0] BOX = 24'hFF4000;
    localparam logic [23:0] BG  = 24'h000040;
`ifdef BOX_BORDER_EN
    localparam logic [23:0] EDGE = 24'hFFFFFF;
`else
    localparam logic [23:0] EDGE = 24'hFF4000;
`endif

    logic clk = 1'b0;
    logic rst, blank_n, hs, vs, frz;
    logic [7:0] r, g, b, r2, g2, b2;
    logic frame, frame2;
    int ncyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {int cyc; int kind; logic [23:0] exp; string nm;} exp_t;
    typedef struct {int x; logic [23:0] rgb; string nm;} px_t;
    exp_t q[$];
    px_t lc[$];

    bouncing_box_renderer d (
        .iVGA_CLK(clk), .iRST(rst), .iBLANK_n(blank_n), .iHS(hs), .iVS(vs), .iFREEZE(frz),
        .oR(r), .oG(g), .oB(b), .oFRAME(frame));
    bouncing_box_renderer #(.STEP(100)) d2 (
        .iVGA_CLK(clk), .iRST(rst), .iBLANK_n(blank_n), .iHS(hs), .iVS(vs), .iFREEZE(frz),
        .oR(r2), .oG(g2), .oB(b2), .oFRAME(frame2));

    always #5 clk = ~clk;
    always @(posedge clk) ncyc <= ncyc + 1;

    function automatic logic [23:0] pos(input int x, input int y);
        return {4'd0, 10'(x), 10'(y)};
    endfunction

    task automatic drive(input logic rr, input logic bb, input logic vv, input logic ff);
        @(negedge clk);
        rst = rr; blank_n = bb; vs = vv; frz = ff;
    endtask

    task automatic expect_v(input int kind, input logic [23:0] e, input string nm);
        q.push_back('{ncyc + 1, kind, e, nm});
    endtask

    task automatic hline(input int n, input logic rst_end);
        for (int k = 0; k < n; k++) begin
            drive(0, 1, 1, 0);
            foreach (lc[i]) if (lc[i].x == k) expect_v(0, lc[i].rgb, lc[i].nm);
        end
        drive(rst_end, rst_end, 1, 0);
        expect_v(0, 24'd0, "line_end");
        lc.delete();
    endtask

    task automatic vsync(input logic f, input logic fexp, input string nm);
        drive(0, 0, 1, f);
        drive(0, 0, 0, f);
        expect_v(1, 24'(fexp), nm);
        drive(0, 0, 0, f);
        expect_v(1, 24'd0, {nm, "_end"});
        drive(0, 0, 1, f);
    endtask

    // Monitor: compares each queued expectation on the cycle it falls due
    initial forever begin
        @(negedge clk);
        while (q.size() > 0 && q[0].cyc <= ncyc) begin
            exp_t e;
            logic [23:0] act;
            e = q.pop_front();
            act = e.kind == 0 ? {r, g, b} : e.kind == 1 ? 24'(frame) :
                  e.kind == 2 ? {4'd0, d.r_bx, d.r_by} : e.kind == 3 ? {4'd0, d2.r_bx, d2.r_by} :
                  e.kind == 4 ? {22'd0, d2.r_dx_neg, d2.r_dy_neg} : {22'd0, d.r_dx_neg, d.r_dy_neg};
            n_cmp++;
            if (act !== e.exp) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h", e.nm, act, e.exp);
            end
        end
    end

    initial begin
        rst = 1; blank_n = 0; hs = 1; vs = 1; frz = 0;
        repeat (3) drive(1, 0, 1, 0);
        expect_v(0, 24'd0, "reset_rgb");
        expect_v(1, 24'd0, "reset_frame");
        expect_v(2, pos(288, 208), "reset_pos");
        // First frame: still waiting for sync, everything dark
        lc.push_back('{290, 24'd0, "sync_wait_px"});
        hline(300, 0);
        vsync(0, 0, "first_vs_no_pulse");
        expect_v(2, pos(288, 208), "first_vs_pos");
        // Second frame: box at (288,208)
        lc.push_back('{0, BG, "bg_origin"});
        hline(1, 0);
        repeat (207) hline(1, 0);
        lc.push_back('{287, BG, "y208_x287"});
        lc.push_back('{288, EDGE, "y208_x288"});
        lc.push_back('{351, EDGE, "y208_x351"});
        lc.push_back('{352, BG, "y208_x352"});
        hline(353, 0);
        hline(1, 0);
        lc.push_back('{288, EDGE, "y210_bx0"});
        lc.push_back('{289, EDGE, "y210_bx1"});
        lc.push_back('{290, BOX, "y210_bx2"});
        lc.push_back('{349, BOX, "y210_bx61"});
        lc.push_back('{351, EDGE, "y210_bx63"});
        lc.push_back('{352, BG, "y210_bx64"});
        hline(353, 0);
        vsync(0, 1, "frame_pulse");
        expect_v(2, pos(290, 210), "step1_pos");
        expect_v(3, pos(388, 308), "s100_step1");
        // Freeze: pulses continue, position held
        repeat (3) begin
            vsync(1, 1, "freeze_pulse");
            expect_v(2, pos(290, 210), "freeze_pos");
            expect_v(3, pos(388, 308), "freeze_pos100");
            expect_v(5, 24'd0, "freeze_dir");
        end
        vsync(0, 1, "release_pulse");
        expect_v(2, pos(292, 212), "release_pos");
        expect_v(3, pos(488, 408), "s100_step2");
        vsync(0, 1, "clamp_pulse");
        expect_v(3, pos(576, 416), "s100_clamp");
        expect_v(4, 24'd3, "s100_dir_neg");
        vsync(0, 1, "back_pulse");
        expect_v(3, pos(476, 316), "s100_back");
        expect_v(2, pos(296, 216), "step4_pos");
        // Reset mid-line at x=300
        lc.push_back('{299, BG, "pre_rst_px"});
        hline(300, 1);
        expect_v(2, pos(288, 208), "rst_pos");
        expect_v(3, pos(288, 208), "rst_pos100");
        lc.push_back('{4, 24'd0, "post_rst_dark"});
        hline(5, 0);
        vsync(0, 0, "post_rst_vs");
        lc.push_back('{0, BG, "restart_bg"});
        hline(1, 0);
        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        if (q.size() > 0) begin
            n_bad += q.size();
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
